// File: rtl/seq_shifter.sv
// Multi-cycle SLL/SRL/SRA/ROTR unit: moves at most STEP bit positions per cycle
// and exchanges operands and results over valid/ready handshakes.
module seq_shifter #(
  parameter  int unsigned WIDTH   = 32,
  parameter  int unsigned STEP    = 8,
  localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               busy
);

  localparam int unsigned CNT_W = SHAMT_W + 1;

  localparam logic [1:0] MODE_SLL  = 2'b00;
  localparam logic [1:0] MODE_SRL  = 2'b01;
  localparam logic [1:0] MODE_SRA  = 2'b10;
  localparam logic [1:0] MODE_ROTR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [1:0]         mode_q, mode_d;

  logic [CNT_W-1:0]   shamt_cap;
  logic [CNT_W-1:0]   amt;
  logic [WIDTH-1:0]   shifted;

  // Non-power-of-two widths can present shamt >= WIDTH; one subtraction suffices
  // because the port range is below 2*WIDTH.
  always_comb begin
    shamt_cap = CNT_W'(in_shamt);
    if (CNT_W'(in_shamt) >= CNT_W'(WIDTH)) begin
      shamt_cap = CNT_W'(in_shamt) - CNT_W'(WIDTH);
    end
  end

  // One bounded step of the captured operation.
  always_comb begin
    amt = (rem_q < CNT_W'(STEP)) ? rem_q : CNT_W'(STEP);
    case (mode_q)
      MODE_SLL:  shifted = data_q << amt;
      MODE_SRL:  shifted = data_q >> amt;
      MODE_SRA:  shifted = WIDTH'($unsigned($signed(data_q) >>> amt));
      MODE_ROTR: shifted = (data_q >> amt) | (data_q << (CNT_W'(WIDTH) - amt));
      default:   shifted = data_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      rem_q  <= '0;
      mode_q <= '0;
    end else begin
      data_q <= data_d;
      rem_q  <= rem_d;
      mode_q <= mode_d;
    end
  end

  // flush overrides every other transition, including a same-cycle request.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            data_d  = in_data;
            mode_d  = in_mode;
            rem_d   = shamt_cap;
            state_d = (shamt_cap == '0) ? ST_DONE : ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          data_d = shifted;
          rem_d  = rem_q - amt;
          if (rem_q == amt) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q != ST_IDLE);
    out_data  = data_q;
  end

endmodule
